seq_detect_prog: RTL and testbench

Programmable serial bit-pattern detector. It generalises the fixed-pattern sequence-detect FSM to any runtime pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping matching, a valid-qualified input and a saturating match counter. It sits on a serial input stream and drives a one-cycle match flag plus statistics to the control logic.

---
 rtl/seq_detect_prog.sv | 133 +++++++++++++
 tb/tb_seq_detect_prog.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial bit-pattern detector with saturating match counter
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    input  logic               clr_cnt,
    output logic               flag,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat,
    output logic [1:0]         state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [1:0]         state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    // Only MAX_LEN-1 past bits are kept; the current bit completes the window.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;

    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] new_hist;
    logic [MAX_LEN-1:0] len_mask;
    logic               accept;
    logic               complete;
    logic               match;

    always_comb begin
        len_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        fill_inc  = fill_q + LEN_W'(1);
        new_hist  = {hist_q, din};
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        accept   = din_valid && !cfg_load && (state_q != S_IDLE);
        complete = accept && ((state_q == S_ARMED) || (fill_inc == len_q));
        match    = complete && (((new_hist ^ pattern_q) & len_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            flag_q    <= flag_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = len_clamp;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = (len_clamp == '0) ? S_IDLE : S_FILL;
        end else if (accept) begin
            hist_d = new_hist[MAX_LEN-2:0];
            if (state_q == S_FILL) begin
                fill_d = fill_inc;
            end
            if (complete) begin
                state_d = S_ARMED;
            end
            // Non-overlapping: a match consumes its bits, so refill from scratch.
            if (match && !overlap_q) begin
                fill_d  = '0;
                state_d = S_FILL;
            end
        end
    end

    always_comb begin
        flag_d = match;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        if (clr_cnt) begin
            cnt_d = match ? CNT_W'(1) : '0;
            sat_d = 1'b0;
        end else if (match) begin
            if (&cnt_q) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign flag      = flag_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
    assign state     = state_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - scoreboard bench for seq_detect_prog
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       din_valid;
    logic       din;
    logic       clr_cnt;
    logic       flag;
    logic [3:0] match_cnt;
    logic       cnt_sat;
    logic [1:0] state;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
        .clr_cnt(clr_cnt), .flag(flag), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .state(state)
    );

    typedef struct {
        logic       flag;
        logic [3:0] cnt;
        logic       sat;
        logic [1:0] st;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int nflags = 0;

    logic [7:0]  m_pat;
    int          m_len, m_fill, m_cnt;
    logic        m_ov, m_sat;
    logic [31:0] m_hist;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [7:0] pat, input logic [3:0] len,
                        input logic ov, input logic v, input logic d, input logic clr);
        exp_t e;
        logic mt;
        rst_n = rst; cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        din_valid = v; din = d; clr_cnt = clr;
        mt = 1'b0;
        if (!rst) begin
            m_pat = '0; m_len = 0; m_ov = 1'b1; m_hist = '0; m_fill = 0; m_cnt = 0; m_sat = 1'b0;
        end else begin
            if (ld) begin
                m_pat = pat; m_len = (len > 8) ? 8 : int'(len); m_ov = ov; m_hist = '0; m_fill = 0;
            end else if (v && m_len != 0) begin
                m_hist = {m_hist[30:0], d};
                if (m_fill < m_len) m_fill++;
                if (m_fill == m_len) begin
                    mt = 1'b1;
                    for (int i = 0; i < m_len; i++) if (m_hist[i] != m_pat[i]) mt = 1'b0;
                end
                if (mt && !m_ov) m_fill = 0;
            end
            if (clr) begin
                m_cnt = mt ? 1 : 0; m_sat = 1'b0;
            end else if (mt) begin
                if (m_cnt == 15) m_sat = 1'b1; else m_cnt++;
            end
        end
        e.flag = mt;
        e.cnt  = 4'(m_cnt);
        e.sat  = m_sat;
        e.st   = (m_len == 0) ? 2'd0 : ((m_fill == m_len) ? 2'd2 : 2'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("flag", 32'(flag), 32'(e.flag));
        check("match_cnt", 32'(match_cnt), 32'(e.cnt));
        check("cnt_sat", 32'(cnt_sat), 32'(e.sat));
        check("state", 32'(state), 32'(e.st));
        if (flag === 1'b1) nflags++;
    endtask

    task automatic bit_in(input logic d);
        step(1'b1, 1'b0, 8'h0, 4'd0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic gap();
        step(1'b1, 1'b0, 8'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        step(1'b1, 1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear();
        step(1'b1, 1'b0, 8'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [6:0] stream7;
    logic [7:0] pat8;

    initial begin
        stream7 = 7'b1011011;
        pat8    = 8'hA5;

        step(1'b0, 1'b0, 8'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("reset_state", 32'(state), 32'd0);

        // Overlapping 1011 over 1011011
        load(8'b1011, 4'd4, 1'b1);
        nflags = 0;
        for (int i = 6; i >= 0; i--) bit_in(stream7[i]);
        check("ov1_flags", 32'(nflags), 32'd2);
        check("ov1_cnt", 32'(match_cnt), 32'd2);
        check("ov1_state", 32'(state), 32'd2);

        // Non-overlapping
        clear();
        load(8'b1011, 4'd4, 1'b0);
        nflags = 0;
        for (int i = 6; i >= 0; i--) begin
            bit_in(stream7[i]);
            if (i == 3) check("ov0_state_after_match", 32'(state), 32'd1);
        end
        check("ov0_flags", 32'(nflags), 32'd1);
        check("ov0_cnt", 32'(match_cnt), 32'd1);

        // Valid gaps between bits
        load(8'b1011, 4'd4, 1'b1);
        nflags = 0;
        for (int i = 3; i >= 0; i--) begin
            bit_in(stream7[i + 3]);
            for (int g = 0; g < 3; g++) gap();
        end
        check("gap_flags", 32'(nflags), 32'd1);

        // Saturation with len=1
        clear();
        load(8'h01, 4'd1, 1'b0);
        for (int i = 0; i < 17; i++) bit_in(1'b1);
        check("sat_cnt", 32'(match_cnt), 32'd15);
        check("sat_flag", 32'(cnt_sat), 32'd1);
        step(1'b1, 1'b0, 8'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_match_cnt", 32'(match_cnt), 32'd1);
        check("clr_match_sat", 32'(cnt_sat), 32'd0);

        // Disabled
        load(8'hFF, 4'd0, 1'b1);
        nflags = 0;
        for (int i = 0; i < 20; i++) bit_in(1'($urandom_range(0, 1)));
        check("len0_flags", 32'(nflags), 32'd0);
        check("len0_state", 32'(state), 32'd0);

        // Length clamp: 12 acts as 8
        load(pat8, 4'd12, 1'b1);
        nflags = 0;
        for (int i = 7; i >= 0; i--) bit_in(pat8[i]);
        check("clamp_flags", 32'(nflags), 32'd1);
        check("clamp_last_flag", 32'(flag), 32'd1);

        // Reset mid-stream, then load coincident with a valid bit
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        step(1'b0, 1'b0, 8'h0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        step(1'b1, 1'b1, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        nflags = 0;
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check("discard_noflag", 32'(nflags), 32'd0);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        check("discard_flags", 32'(nflags), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
